// File: rtl/store_pkg.sv
// Shared types and helpers for the store read-modify-write controller.
// Store sizes, lane masks and alignment rules are defined here once for every user.
package store_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    ERR
  } state_t;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Size in bytes from the low two funct3 bits (sb/sh/sw/sd).
  function automatic logic [3:0] store_size(input logic [1:0] code);
    case (code)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] code);
    case (code)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // A store is misaligned when any offset bit below its natural size is set.
  function automatic logic misaligned(input logic [1:0] code, input logic [2:0] off);
    return (({1'b0, off} & (store_size(code) - 4'd1)) != 4'd0);
  endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Request and data-memory bus of the store controller.
// The master side is the pipeline and memory, the slave side is the controller.
interface store_rmw_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [63:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_wr_en;
  logic [63:0]       mem_wdata;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output req_valid, req_funct3, req_addr, req_data, mem_rdata, mem_rvalid,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, err_code
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_data, mem_rdata, mem_rvalid,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, err_code
  );
endinterface

// File: rtl/store_merge.sv
// Combinational byte-lane merge: the low size bytes of new_data replace
// bytes off..off+size-1 of old_word, little-endian.
module store_merge
  import store_pkg::*;
(
  input  logic [1:0]  size_code,
  input  logic [2:0]  off,
  input  logic [63:0] old_word,
  input  logic [63:0] new_data,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] lane_mask;
  logic [63:0] shifted;

  always_comb begin
    shamt     = {off, 3'b000};
    lane_mask = size_mask(size_code) << shamt;
    shifted   = new_data << shamt;
    merged    = (old_word & ~lane_mask) | (shifted & lane_mask);
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store controller for a 64-bit memory without byte enables: sd is written
// directly, sb/sh/sw go through read-modify-write with a bounded read wait.
module store_rmw_ctrl
  import store_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  store_rmw_ctrl_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         size_q;
  logic [2:0]         off_q;
  logic [63:0]        data_q;
  logic [63:0]        merged;
  logic               accept;

  assign accept = bus.req_valid && bus.req_ready;

  store_merge u_merge (
    .size_code (size_q),
    .off       (off_q),
    .old_word  (bus.mem_rdata),
    .new_data  (data_q),
    .merged    (merged)
  );

  // Request fields are only consumed after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      size_q <= bus.req_funct3[1:0];
      off_q  <= bus.req_addr[2:0];
      data_q <= bus.req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_rd_en <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_code  <= ERR_NONE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
            if (bus.req_funct3[2]) begin
              state        <= ERR;
              bus.err      <= 1'b1;
              bus.err_code <= ERR_FUNCT3;
            end else if (misaligned(bus.req_funct3[1:0], bus.req_addr[2:0])) begin
              state        <= ERR;
              bus.err      <= 1'b1;
              bus.err_code <= ERR_MISALIGN;
            end else if (bus.req_funct3 == F3_SD) begin
              state         <= WRITE;
              bus.mem_wr_en <= 1'b1;
              bus.done      <= 1'b1;
              bus.mem_wdata <= bus.req_data;
            end else begin
              state         <= READ;
              bus.mem_rd_en <= 1'b1;
            end
          end
        end
        READ: begin
          cnt   <= '0;
          state <= WAIT;
        end
        // A response in the final wait cycle still wins over the timeout.
        WAIT: begin
          if (bus.mem_rvalid) begin
            state         <= WRITE;
            bus.mem_wr_en <= 1'b1;
            bus.done      <= 1'b1;
            bus.mem_wdata <= merged;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= ERR;
            bus.err      <= 1'b1;
            bus.err_code <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        ERR: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.err_code  <= ERR_NONE;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Scoreboard bench for store_rmw_ctrl: directed spec cases plus random stores
// against a byte-level memory model, with a memory responder and an output monitor.
module tb_store_rmw_ctrl;

  localparam int TO = 15;

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  code;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_rmw_ctrl_if #(.ADDR_W(64)) bus ();

  store_rmw_ctrl #(.ADDR_W(64), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  rd_t         rd_q[$];
  int          dq[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          prev_end = -1;
  bit          stray_en = 1'b0;
  bit          force_rv = 1'b0;
  logic [63:0] ref_mem[32];
  int          poke_seq = 0;
  int          poke_idx = 0;
  logic [63:0] poke_val = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input int i);
    return 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory responder: owns the memory image, answers reads after the delay queued per request.
  initial begin
    logic [63:0] ram[32];
    bit          pend;
    int          pend_cyc;
    logic [63:0] pend_addr;
    int          seen_seq;
    int          d;
    for (int i = 0; i < 32; i++) ram[i] = init_word(i);
    pend = 1'b0; pend_cyc = 0; pend_addr = '0; seen_seq = 0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = {$urandom, $urandom};
      if (seen_seq != poke_seq) begin
        ram[poke_idx] = poke_val;
        seen_seq = poke_seq;
      end
      if (!rst_n) begin
        pend = 1'b0;
        dq.delete();
      end else begin
        if (bus.mem_wr_en) ram[bus.mem_addr[7:3]] = bus.mem_wdata;
        if (bus.mem_rd_en) begin
          d = 0;
          if (dq.size() > 0) d = dq.pop_front();
          if (d > 0) begin
            pend = 1'b1;
            pend_cyc = cyc + d;
            pend_addr = bus.mem_addr;
          end
        end
        if (pend && cyc == pend_cyc) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = ram[pend_addr[7:3]];
          pend = 1'b0;
        end else if (stray_en && bus.req_ready && !pend) begin
          bus.mem_rvalid = 1'($urandom_range(0, 1));
        end
      end
      if (force_rv) bus.mem_rvalid = 1'b1;
    end
  end

  // Monitor: every read, write or error pulse is matched against the scoreboard.
  initial begin
    exp_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_rd_en) begin
          if (rd_q.size() == 0) fail_now("unexpected_read");
          else begin
            r = rd_q.pop_front();
            check("rd_cycle", 64'(cyc), 64'(r.cyc));
            check("rd_addr", bus.mem_addr, r.addr);
          end
          check("rd_alone", {62'd0, bus.mem_wr_en, bus.err}, 64'd0);
        end
        if (bus.mem_wr_en || bus.err || bus.done) begin
          if (exp_q.size() == 0) fail_now("unexpected_output");
          else begin
            e = exp_q.pop_front();
            check("is_err", 64'(bus.err), 64'(e.is_err));
            check("out_cycle", 64'(cyc), 64'(e.cyc));
            check("done_eq_wr", 64'(bus.done), 64'(bus.mem_wr_en));
            if (e.is_err) begin
              check("err_code", 64'(bus.err_code), 64'(e.code));
              check("no_wr_on_err", 64'(bus.mem_wr_en), 64'd0);
            end else begin
              check("wr_addr", bus.mem_addr, e.addr);
              check("wr_data", bus.mem_wdata, e.wdata);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic set_mem(input int idx, input logic [63:0] val);
    ref_mem[idx] = val;
    poke_idx = idx;
    poke_val = val;
    poke_seq++;
    repeat (2) @(negedge clk);
  endtask

  // Issue one store at a negedge; returns one cycle after it is accepted.
  task automatic issue(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data,
                       input int d, input bit ov, input logic [63:0] ov_w);
    exp_t        e;
    rd_t         r;
    int          waited;
    int          sz;
    int          off;
    logic [63:0] w;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_data   = data;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bus.req_ready !== 1'b1) begin
      fail_now("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    if (prev_end >= 0) check("b2b_accept_cycle", 64'(cyc), 64'(prev_end + 1));
    sz  = 1 << f3[1:0];
    off = int'(addr[2:0]);
    e.addr = {addr[63:3], 3'b000};
    e.code = 2'b00;
    e.wdata = '0;
    e.is_err = 1'b0;
    if (f3[2]) begin
      e.is_err = 1'b1; e.code = 2'b10; e.cyc = cyc + 1;
    end else if (off % sz != 0) begin
      e.is_err = 1'b1; e.code = 2'b01; e.cyc = cyc + 1;
    end else begin
      w = ref_mem[addr[7:3]];
      for (int i = 0; i < sz; i++) w[(off + i) * 8 +: 8] = data[i * 8 +: 8];
      if (ov) w = ov_w;
      e.wdata = w;
      if (sz == 8) begin
        e.cyc = cyc + 1;
        ref_mem[addr[7:3]] = w;
      end else begin
        r.cyc = cyc + 1;
        r.addr = e.addr;
        rd_q.push_back(r);
        dq.push_back(d);
        if (d == 0) begin
          e.is_err = 1'b1; e.code = 2'b11; e.cyc = cyc + 2 + TO;
        end else begin
          e.cyc = cyc + 2 + d;
          ref_mem[addr[7:3]] = w;
        end
      end
    end
    prev_end = e.cyc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = {$urandom, $urandom};
    bus.req_data   = {$urandom, $urandom};
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(negedge clk);
    check("ready_when_idle", 64'(bus.req_ready), 64'd1);
    prev_end = -1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_err_code", 64'(bus.err_code), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [63:0] a;
    int          d;
    int          rr;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    set_mem(0, 64'h1122_3344_5566_7788);
    issue(3'b000, 64'h1003, 64'hAB, 2, 1'b1, 64'h1122_3344_AB66_7788);
    drain();
    set_mem(0, 64'h1122_3344_5566_7788);
    issue(3'b001, 64'h1006, 64'hBEEF, 1, 1'b1, 64'hBEEF_3344_5566_7788);
    drain();
    set_mem(0, 64'h1122_3344_5566_7788);
    issue(3'b010, 64'h1004, 64'hDEAD_BEEF, 3, 1'b1, 64'hDEAD_BEEF_5566_7788);
    drain();

    issue(3'b011, 64'h2008, 64'h0123_4567_89AB_CDEF, 0, 1'b1, 64'h0123_4567_89AB_CDEF);
    issue(3'b010, 64'h1002, 64'hCAFE_F00D, 0, 1'b0, 64'h0);
    issue(3'b100, 64'h1000, 64'h1234, 0, 1'b0, 64'h0);
    issue(3'b000, 64'h1005, 64'h5A, 1, 1'b0, 64'h0);
    drain();

    issue(3'b000, 64'h1001, 64'h77, 0, 1'b0, 64'h0);
    drain();
    issue(3'b000, 64'h1001, 64'h66, TO, 1'b0, 64'h0);
    drain();

    stray_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(4, 7));
      else f3 = 3'($urandom_range(0, 3));
      a = 64'h1000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
      rr = $urandom_range(0, 19);
      if (rr == 0) d = 0;
      else if (rr == 1) d = TO;
      else d = $urandom_range(1, 14);
      issue(f3, a, {$urandom, $urandom}, d, 1'b0, 64'h0);
      if ($urandom_range(0, 7) == 0) drain();
    end
    drain();
    stray_en = 1'b0;

    issue(3'b000, 64'h1008, 64'h11, 0, 1'b0, 64'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    rd_q.delete();
    prev_end = -1;
    @(negedge clk);
    check_reset_outputs();
    force_rv = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.req_ready), 64'd1);
    repeat (3) @(negedge clk);
    force_rv = 1'b0;
    repeat (20) @(negedge clk);
    check("no_wr_after_reset", 64'(bus.mem_wdata), 64'd0);
    issue(3'b001, 64'h1012, 64'h4321, 2, 1'b0, 64'h0);
    drain();

    check("reads_outstanding", 64'(rd_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
Sequential store controller that sits directly downstream of the store-select stage, between the execute/memory pipeline stage and the 64-bit data memory. The data memory has no byte enables, so sub-doubleword stores (sb/sh/sw) are performed as read-modify-write; sd is written directly. The block stalls the pipeline through a valid/ready handshake and reports misaligned or unsupported stores and memory read timeouts.

Parameters:
ADDR_W, 64, byte address width
TIMEOUT, 15, maximum cycles spent in RD_WAIT before aborting (4-bit counter minimum)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  store request present
req_ready  out  1  controller can accept a request (IDLE only)
req_funct3  in  3  store funct3: 000 sb, 001 sh, 010 sw, 011 sd
req_addr  in  ADDR_W  byte address
req_data  in  64  rs2 value; the low bytes are used according to size
mem_addr  out  ADDR_W  doubleword-aligned address {addr[ADDR_W-1:3],3'b0}
mem_rd_en  out  1  one-cycle read strobe
mem_rdata  in  64  read data
mem_rvalid  in  1  read data valid
mem_wr_en  out  1  one-cycle write strobe
mem_wdata  out  64  full doubleword to write
done  out  1  one-cycle pulse: store committed
err  out  1  one-cycle pulse: store aborted
err_code  out  2  00 none, 01 misaligned, 10 bad funct3, 11 timeout; valid while err=1

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; req_ready=1; mem_rd_en, mem_wr_en, done, err=0; err_code=00; mem_addr and mem_wdata are 0; the timeout counter is 0. A reset during any state abandons the operation, and no write is issued afterwards.
- States: IDLE, READ, WAIT, WRITE, ERR.
- IDLE: req_ready=1. On req_valid&&req_ready, latch funct3, addr and data.
  - funct3[2]=1 -> ERR with code 10.
  - Misaligned -> ERR with code 01. Misaligned means: sd with addr[2:0]!=0, sw with addr[1:0]!=0, or sh with addr[0]!=0.
  - sd -> WRITE, with wdata=req_data.
  - Otherwise -> READ.
- READ: mem_rd_en=1 and mem_addr valid for exactly one cycle; clear the counter; go to WAIT.
- WAIT: on mem_rvalid, merge and go to WRITE. Otherwise increment the counter; when counter==TIMEOUT -> ERR with code 11. An rvalid arriving in the same cycle as counter==TIMEOUT counts as success (rvalid has priority).
- Merge: the byte lane is off=addr[2:0]. Replace bytes off..off+size-1 of mem_rdata with the low size bytes of req_data; all other bytes are preserved. Little-endian; size is 1/2/4 bytes.
- WRITE: mem_wr_en=1, mem_addr and mem_wdata valid, done=1 for one cycle; next state IDLE.
- ERR: err=1 and err_code held for one cycle; no memory strobes; next state IDLE.
- req_ready=0 in every state except IDLE. Requests presented while not ready are ignored, and the requester holds them.
- mem_rvalid outside WAIT is ignored.
- Latency from the accept cycle T:
  - sd: write and done at T+1.
  - RMW: read at T+1; rvalid at the earliest at T+2; write and done one cycle after rvalid.
  - Errors (codes 01/10): err at T+1.
- Back-to-back: the next request can be accepted in the cycle after done or err.
- All outputs are registered or decoded from state. No combinational path from req_* to mem_* strobes.

Decomposition:
- Shared package store_pkg:
  - state enum
  - funct3 constants F3_SB/F3_SH/F3_SW/F3_SD
  - OPCODE_STORE = 7'b0100011
  - err_code constants
  - size-from-funct3 function
- Sub-module store_merge: purely combinational byte-lane merge (funct3, off, old word, new data -> merged word). It is instantiated once.

Test Plan:
- sb at 0x1003, data 0xAB, mem_rdata 0x1122334455667788 -> one rd_en at mem_addr 0x1000, then wr_en with wdata 0x11223344AB667788 and done pulse.
- sh at 0x1006, data 0xBEEF, same memory -> wdata 0xBEEF334455667788. sw at 0x1004, data 0xDEADBEEF -> wdata 0xDEADBEEF55667788.
- sd at 0x2008, data 0x0123456789ABCDEF -> no rd_en; wr_en at T+1, mem_addr 0x2008, done at T+1.
- Error cases:
  - sw at 0x1002 -> err=1, code 01 at T+1, no strobes.
  - funct3=100 -> code 10.
  - Both cases -> req_ready=1 again the next cycle.
- sb with mem_rvalid never asserted -> err with code 11 after TIMEOUT=15 WAIT cycles, no wr_en. A repeat of the test with rvalid exactly on the 15th cycle -> normal write.
- Reset mid-op: rst_n=0 while in WAIT, then rvalid -> no wr_en, outputs at reset values, req_ready=1 after release.
